// File: rtl/fifo_wptr_full.sv
// Write-side pointer/full controller for an async FIFO: binary + Gray write pointer,
// read-pointer synchroniser, registered full flag, fill level and overflow pulse.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  push_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_i,
    output logic                  push_accept_o,
    output logic [ADDR_WIDTH-1:0] wptr_bin_o,
    output logic [ADDR_WIDTH:0]   wptr_gray_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   wr_count_o,
    output logic                  overflow_o
);
    localparam int AW = ADDR_WIDTH;

    logic [AW:0]                  wbin, wgray, wbin_next, wgray_next;
    logic [SYNC_STAGES-1:0][AW:0] rsync;
    logic [AW:0]                  rq, rbin, full_cmp;
    logic                         full, ovf;

    assign push_accept_o = push_i & ~full;
    assign wbin_next     = wbin + {{AW{1'b0}}, push_accept_o};
    assign wgray_next    = wbin_next ^ (wbin_next >> 1);

    assign rq = rsync[SYNC_STAGES-1];

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_cmp = {~rq[AW:AW-1], rq[AW-2:0]};

    // Gray-to-binary: bit i is the XOR of all Gray bits from i upward.
    for (genvar i = 0; i <= AW; i++) begin : g_g2b
        assign rbin[i] = ^(rq >> i);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wbin  <= '0;
            wgray <= '0;
            full  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= wgray_next;
            full  <= (wgray_next == full_cmp);
            ovf   <= push_i & full;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rsync <= '0;
        end else begin
            rsync[0] <= rptr_gray_i;
            for (int s = 1; s < SYNC_STAGES; s++) rsync[s] <= rsync[s-1];
        end
    end

    assign wptr_bin_o  = wbin[AW-1:0];
    assign wptr_gray_o = wgray;
    assign full_o      = full;
    assign overflow_o  = ovf;
    assign wr_count_o  = wbin - rbin;
endmodule
